// File: rtl/pe_out_channel.sv
// PE output channel: reserves slots on fu_alloc, fills them in order on fu_valid, and
// broadcasts the head entry to masked destinations. Optional stall counter: PE_OCH_STALL_CNT_EN.
module pe_out_channel #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2,
  parameter int NUM_DEST   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_en,
  input  logic [NUM_DEST-1:0]        cfg_dest_mask,
  input  logic                       fu_alloc,
  output logic                       ch_ready,
  input  logic                       fu_valid,
  input  logic [DATA_WIDTH-1:0]      fu_out,
  output logic [NUM_DEST-1:0]        dst_valid,
  output logic [DATA_WIDTH-1:0]      dst_data,
  input  logic [NUM_DEST-1:0]        dst_ready,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic                       err,
  output logic [31:0]                stall_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0]      filled;
  logic [NUM_DEST-1:0]   sent;
  logic [NUM_DEST-1:0]   mask;
  logic [PW-1:0]         alloc_ptr;
  logic [PW-1:0]         fill_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [OW-1:0]         occ;
  logic [OW-1:0]         res_cnt;
  logic                  err_q;

  logic                  head_full;
  logic [NUM_DEST-1:0]   hs;
  logic                  pop;
  logic                  alloc_ok;
  logic                  fill_ok;
  logic                  cfg_ok;

  always_comb begin
    head_full = filled[rd_ptr];
    ch_ready  = (occ < OW'(DEPTH));
    dst_valid = head_full ? (mask & ~sent) : '0;
    hs        = dst_valid & dst_ready;
    pop       = head_full & (&(sent | hs | ~mask));
    alloc_ok  = fu_alloc & ch_ready;
    // Fills only pair with reservations made in earlier cycles.
    fill_ok   = fu_valid & (res_cnt != '0);
    cfg_ok    = cfg_en & (occ == '0);
  end

  assign dst_data  = mem[rd_ptr];
  assign occupancy = occ;
  assign err       = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      filled    <= '0;
      sent      <= '0;
      mask      <= '1;
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
      res_cnt   <= '0;
      err_q     <= 1'b0;
    end else begin
      if (alloc_ok) alloc_ptr <= alloc_ptr + PW'(1);
      // A filling slot is never the filled head, so the two filled updates never collide.
      if (pop) filled[rd_ptr] <= 1'b0;
      if (fill_ok) begin
        mem[fill_ptr]    <= fu_out;
        filled[fill_ptr] <= 1'b1;
        fill_ptr         <= fill_ptr + PW'(1);
      end
      if (pop) begin
        sent   <= '0;
        rd_ptr <= rd_ptr + PW'(1);
      end else begin
        sent <= sent | hs;
      end
      occ     <= occ + OW'(alloc_ok) - OW'(pop);
      res_cnt <= res_cnt + OW'(alloc_ok) - OW'(fill_ok);
      if (cfg_ok) mask <= cfg_dest_mask;
      if ((fu_valid & ~fill_ok) | (cfg_en & ~cfg_ok)) err_q <= 1'b1;
    end
  end

`ifdef PE_OCH_STALL_CNT_EN
  logic [31:0] stall_q;
  logic        stall_inc;

  assign stall_inc = head_full & (|(dst_valid & ~dst_ready));
  assign stall_cnt = stall_q;

  always_ff @(posedge clk) begin
    if (rst || cfg_ok) begin
      stall_q <= '0;
    end else if (stall_inc && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pe_out_channel.sv
// Scoreboard bench for pe_out_channel: an entry-queue reference model predicts state,
// and a monitor checks every destination handshake against the expected result stream.
module tb_pe_out_channel;

  localparam int DW    = 32;
  localparam int DEPTH = 2;
  localparam int ND    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_en;
  logic [ND-1:0] cfg_dest_mask;
  logic          fu_alloc;
  logic          ch_ready;
  logic          fu_valid;
  logic [DW-1:0] fu_out;
  logic [ND-1:0] dst_valid;
  logic [DW-1:0] dst_data;
  logic [ND-1:0] dst_ready;
  logic [$clog2(DEPTH):0] occupancy;
  logic          err;
  logic [31:0]   stall_cnt;

  pe_out_channel #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_DEST(ND)) dut (
    .clk(clk), .rst(rst), .cfg_en(cfg_en), .cfg_dest_mask(cfg_dest_mask),
    .fu_alloc(fu_alloc), .ch_ready(ch_ready), .fu_valid(fu_valid), .fu_out(fu_out),
    .dst_valid(dst_valid), .dst_data(dst_data), .dst_ready(dst_ready),
    .occupancy(occupancy), .err(err), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            filled;
    logic [DW-1:0] data;
    logic [ND-1:0] sent;
  } ent_t;

  typedef struct {
    logic [DW-1:0] data;
    logic [ND-1:0] mask;
  } exp_t;

  ent_t          mq[$];     // slots in reservation order, head first
  exp_t          exp_q[$];  // results still owed to the destinations
  logic [ND-1:0] m_mask;
  bit            m_err;
  logic [31:0]   m_stall;
  bit            armed = 0;
  logic [ND-1:0] mon_done = '0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: advances the slot queue once per clock from the applied inputs.
  always @(posedge clk) begin
    int n, res, fidx;
    bit hf, pop;
    logic [ND-1:0] dv, acc;
    ent_t e;
    exp_t x;
    n = mq.size();
    res = 0;
    fidx = -1;
    foreach (mq[k]) if (!mq[k].filled) begin
      res++;
      if (fidx < 0) fidx = k;
    end
    if (rst) begin
      mq.delete();
      exp_q.delete();
      m_mask  = '1;
      m_err   = 0;
      m_stall = '0;
      armed   = 1;
    end else if (armed) begin
      hf  = (n > 0) && mq[0].filled;
      dv  = hf ? (m_mask & ~mq[0].sent) : '0;
      acc = dv & dst_ready;
      pop = hf && ((mq[0].sent | acc | ~m_mask) == '1);
      if (hf && (|(dv & ~dst_ready)) && (m_stall != 32'hFFFF_FFFF)) m_stall++;
      if (fu_valid) begin
        if (res > 0) begin
          e = mq[fidx];
          e.filled = 1;
          e.data = fu_out;
          mq[fidx] = e;
          if (m_mask != '0) begin
            x.data = fu_out;
            x.mask = m_mask;
            exp_q.push_back(x);
          end
        end else begin
          m_err = 1;
        end
      end
      if (pop) begin
        void'(mq.pop_front());
      end else if (n > 0) begin
        e = mq[0];
        e.sent = e.sent | acc;
        mq[0] = e;
      end
      if (fu_alloc && n < DEPTH) begin
        e.filled = 0;
        e.data = '0;
        e.sent = '0;
        mq.push_back(e);
      end
      if (cfg_en) begin
        if (n == 0) begin
          m_mask  = cfg_dest_mask;
          m_stall = '0;
        end else begin
          m_err = 1;
        end
      end
    end
  end

  // State checks plus handshake monitor, sampled mid-cycle.
  always @(negedge clk) begin
    bit hf;
    logic [ND-1:0] e_dv, hs, owed;
    if (armed) begin
      hf   = (mq.size() > 0) && mq[0].filled;
      e_dv = hf ? (m_mask & ~mq[0].sent) : '0;
      chk("ch_ready", 32'(ch_ready), 32'(mq.size() < DEPTH));
      chk("occupancy", 32'(occupancy), 32'(mq.size()));
      chk("dst_valid", 32'(dst_valid), 32'(e_dv));
      chk("err", 32'(err), 32'(m_err));
`ifdef PE_OCH_STALL_CNT_EN
      chk("stall_cnt", stall_cnt, m_stall);
`else
      chk("stall_cnt", stall_cnt, 32'd0);
`endif
      if (rst) begin
        mon_done = '0;
      end else begin
        hs = dst_valid & dst_ready;
        if (hs != '0) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_output", 32'(hs), 32'd0);
          end else begin
            owed = exp_q[0].mask & ~mon_done;
            chk("dst_data", dst_data, exp_q[0].data);
            chk("dup_or_stray_hs", 32'(hs & ~owed), 32'd0);
            mon_done = mon_done | hs;
            if ((mon_done & exp_q[0].mask) == exp_q[0].mask) begin
              void'(exp_q.pop_front());
              mon_done = '0;
            end
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic cfg(input logic [ND-1:0] m);
    cfg_en = 1'b1;
    cfg_dest_mask = m;
    cyc();
    cfg_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cfg_en = 0; cfg_dest_mask = '0; fu_alloc = 0; fu_valid = 0;
    fu_out = '0; dst_ready = '0;
    repeat (2) cyc();
    rst = 1'b0;
    cyc();

    // Basic: alloc, fill DEADBEEF, two destinations.
    cfg(4'b0011);
    fu_alloc = 1; cyc(); fu_alloc = 0;
    fu_valid = 1; fu_out = 32'hDEAD_BEEF; dst_ready = 4'b0011; cyc();
    fu_valid = 0; repeat (3) cyc();

    // Full channel with backpressure, then in-order release.
    cfg(4'b1111); dst_ready = '0;
    fu_alloc = 1; repeat (3) cyc(); fu_alloc = 0;
    fu_valid = 1; fu_out = 32'hAAAA_0001; cyc();
    fu_out = 32'hBBBB_0002; cyc();
    fu_valid = 0; repeat (3) cyc();
    dst_ready = 4'b1111; repeat (4) cyc();

    // Staggered per-destination acceptance.
    dst_ready = '0;
    fu_alloc = 1; cyc(); fu_alloc = 0;
    fu_valid = 1; fu_out = 32'h1234_5678; cyc(); fu_valid = 0;
    dst_ready = 4'b0001; cyc();
    dst_ready = 4'b0100; cyc();
    dst_ready = 4'b0000; cyc();
    dst_ready = 4'b1010; cyc();
    dst_ready = 4'b0000; repeat (2) cyc();

    // Protocol errors: unreserved fill, config while busy.
    fu_valid = 1; fu_out = 32'h0BAD_0BAD; cyc(); fu_valid = 0;
    fu_alloc = 1; cyc(); fu_alloc = 0;
    cfg(4'b0001);
    dst_ready = 4'b1111; fu_valid = 1; fu_out = 32'hC0DE_0001; cyc();
    fu_valid = 0; repeat (3) cyc();

    // Back-to-back alloc+fill, pointer wrap.
    do_reset();
    fu_alloc = 1; cyc();
    fu_valid = 1;
    for (int i = 0; i < 12; i++) begin
      fu_out = 32'h5000_0000 + 32'(i);
      cyc();
    end
    fu_alloc = 0; fu_valid = 0; repeat (4) cyc();

    // Stall on one destination, then reset mid-stall.
    do_reset();
    dst_ready = 4'b1101;
    fu_alloc = 1; cyc(); fu_alloc = 0;
    fu_valid = 1; fu_out = 32'h7777_0007; cyc(); fu_valid = 0;
    repeat (7) cyc();
    rst = 1'b1; cyc(); rst = 1'b0; repeat (2) cyc();

    // Randomized traffic including mask 0 and occasional resets.
    for (int i = 0; i < 600; i++) begin
      rst           = ($urandom_range(0, 149) == 0);
      cfg_en        = ($urandom_range(0, 19) == 0);
      cfg_dest_mask = ND'($urandom);
      fu_alloc      = ($urandom_range(0, 1) == 1);
      fu_valid      = ($urandom_range(0, 9) < 4);
      fu_out        = $urandom;
      dst_ready     = ND'($urandom);
      cyc();
    end
    rst = 0; cfg_en = 0; fu_alloc = 0; fu_valid = 0; dst_ready = '1;
    repeat (8) cyc();
    chk("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
